// File: rtl/sha256_round_ctrl.sv
// sha256_round_ctrl
// Sequencer for one SHA-256 compression block. Loads 16 message words into
// the schedule, steps 64 rounds while addressing the K ROM, then commands the
// hash-value add-back and pulses done.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      synchronous active-low reset
//   start      block request, accepted only while ready
//   first      sampled with an accepted start; 1 = load the IV (init_hv)
//   abort      return to IDLE next cycle, no add_en / done
//   hold       freezes round progress while in ROUND
//   msg_valid  message word present on the datapath input
//   msg_ready  controller accepts a word this cycle (LOAD)
//   w_we       write accepted word into schedule slot w_idx
//   w_idx      schedule slot 0..15 for the current load
//   w_sel      0 = loaded word (rounds 0..15), 1 = expanded word (16..63)
//   k_addr     K ROM address = current round number
//   rnd_en     datapath performs one round this cycle
//   init_hv    load the IV into the hash registers
//   add_en     add working variables into the hash registers
//   ready      idle, can accept start
//   busy       in LOAD, ROUND or ADD
//   done       one-cycle pulse, digest valid
module sha256_round_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       first,
  input  logic       abort,
  input  logic       hold,
  input  logic       msg_valid,
  output logic       msg_ready,
  output logic       w_we,
  output logic [3:0] w_idx,
  output logic       w_sel,
  output logic [5:0] k_addr,
  output logic       rnd_en,
  output logic       init_hv,
  output logic       add_en,
  output logic       ready,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ROUND = 3'd2,
    S_ADD   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] w_cnt, w_cnt_nxt;
  logic [5:0] rnd_cnt, rnd_cnt_nxt;

  // State and counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      w_cnt   <= 4'd0;
      rnd_cnt <= 6'd0;
    end else begin
      state   <= state_nxt;
      w_cnt   <= w_cnt_nxt;
      rnd_cnt <= rnd_cnt_nxt;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_nxt   = state;
    w_cnt_nxt   = w_cnt;
    rnd_cnt_nxt = rnd_cnt;
    if (abort) begin
      // Abort outranks every other input in every state.
      state_nxt   = S_IDLE;
      w_cnt_nxt   = 4'd0;
      rnd_cnt_nxt = 6'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state_nxt = S_LOAD;
            w_cnt_nxt = 4'd0;
          end
        end
        S_LOAD: begin
          if (msg_valid) begin
            if (w_cnt == 4'd15) begin
              state_nxt   = S_ROUND;
              w_cnt_nxt   = 4'd0;
              rnd_cnt_nxt = 6'd0;
            end else begin
              w_cnt_nxt = w_cnt + 4'd1;
            end
          end
        end
        S_ROUND: begin
          if (!hold) begin
            // Round 63 leaves ROUND instead of wrapping the counter.
            if (rnd_cnt == 6'd63) begin
              state_nxt   = S_ADD;
              rnd_cnt_nxt = 6'd0;
            end else begin
              rnd_cnt_nxt = rnd_cnt + 6'd1;
            end
          end
        end
        S_ADD:   state_nxt = S_DONE;
        S_DONE:  state_nxt = S_IDLE;
        default: begin
          state_nxt   = S_IDLE;
          w_cnt_nxt   = 4'd0;
          rnd_cnt_nxt = 6'd0;
        end
      endcase
    end
  end

  // Output decode; strobes are suppressed by abort so nothing is committed
  // in the cycle that is being thrown away.
  always_comb begin
    msg_ready = 1'b0;
    w_we      = 1'b0;
    w_idx     = 4'd0;
    w_sel     = 1'b0;
    k_addr    = 6'd0;
    rnd_en    = 1'b0;
    init_hv   = 1'b0;
    add_en    = 1'b0;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        ready   = 1'b1;
        init_hv = start & first & ~abort;
      end
      S_LOAD: begin
        busy      = 1'b1;
        msg_ready = 1'b1;
        w_idx     = w_cnt;
        w_we      = msg_valid & ~abort;
      end
      S_ROUND: begin
        busy   = 1'b1;
        k_addr = rnd_cnt;
        w_sel  = (rnd_cnt[5:4] != 2'b00);
        rnd_en = ~hold & ~abort;
      end
      S_ADD: begin
        busy   = 1'b1;
        add_en = ~abort;
      end
      S_DONE: begin
        done = ~abort;
      end
      default: begin
        ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// tb_sha256_round_ctrl
// Directed bench for sha256_round_ctrl: nominal block, back-to-back blocks,
// gapped load, hold stalls, ignored protocol violations, abort and reset.
module tb_sha256_round_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       first = 1'b0;
  logic       abort = 1'b0;
  logic       hold = 1'b0;
  logic       msg_valid = 1'b0;
  logic       msg_ready, w_we, w_sel, rnd_en, init_hv, add_en, ready, busy, done;
  logic [3:0] w_idx;
  logic [5:0] k_addr;

  sha256_round_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .first     (first),
    .abort     (abort),
    .hold      (hold),
    .msg_valid (msg_valid),
    .msg_ready (msg_ready),
    .w_we      (w_we),
    .w_idx     (w_idx),
    .w_sel     (w_sel),
    .k_addr    (k_addr),
    .rnd_en    (rnd_en),
    .init_hv   (init_hv),
    .add_en    (add_en),
    .ready     (ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Cycle monitor: counts strobes and tracks the expected slot / round
  // sequence so that skips, repeats or moves during hold are caught.
  logic in_round = 1'b0;
  int cnt_we = 0, cnt_rnd = 0, cnt_add = 0, cnt_done = 0, cnt_init = 0;
  int add_cyc = 0, done_cyc = 0, init_cyc = 0;
  int idx_bad = 0, k_bad = 0, sel_bad = 0, hold_bad = 0;
  int exp_idx = 0, exp_k = 0;

  always @(negedge clk) begin
    if (w_we) begin
      if (w_idx != exp_idx[3:0]) idx_bad <= idx_bad + 1;
      exp_idx <= exp_idx + 1;
      cnt_we  <= cnt_we + 1;
    end else if (!msg_ready) begin
      exp_idx <= 0;
    end
    if (rnd_en) begin
      if (k_addr != exp_k[5:0]) k_bad <= k_bad + 1;
      if (w_sel != (exp_k >= 16)) sel_bad <= sel_bad + 1;
      exp_k   <= exp_k + 1;
      cnt_rnd <= cnt_rnd + 1;
    end else if (ready) begin
      exp_k <= 0;
    end
    if (in_round && hold && (rnd_en || k_addr != exp_k[5:0])) hold_bad <= hold_bad + 1;
    if (add_en)  begin cnt_add  <= cnt_add + 1;  add_cyc  <= cyc; end
    if (done)    begin cnt_done <= cnt_done + 1; done_cyc <= cyc; end
    if (init_hv) begin cnt_init <= cnt_init + 1; init_cyc <= cyc; end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // Runs one block starting in the current (IDLE) cycle and leaves the bench
  // in the first IDLE cycle after DONE.
  task automatic do_block(input bit f, input bit gapped, input bit hm,
                          input bit noise, input int exp_done);
    int t, acc, r, held;
    bit ph;
    int b_we, b_rnd, b_add, b_done, b_init, b_idx, b_k, b_sel, b_hold;
    b_we = cnt_we; b_rnd = cnt_rnd; b_add = cnt_add; b_done = cnt_done;
    b_init = cnt_init; b_idx = idx_bad; b_k = k_bad; b_sel = sel_bad;
    b_hold = hold_bad;
    start = 1'b1;
    first = f;
    t = cyc;
    next();
    start = 1'b0;
    first = 1'b0;
    acc = 0;
    ph = !gapped;
    while (acc < 16) begin
      msg_valid = ph;
      if (ph) acc++;
      if (gapped) ph = !ph;
      start = noise && (acc == 5);
      next();
    end
    msg_valid = 1'b0;
    start = 1'b0;
    in_round = 1'b1;
    r = 0;
    held = 0;
    while (r < 64) begin
      msg_valid = noise;
      start = noise && (r == 30);
      if (hm && (r == 15 || r == 63) && held < 3) begin
        hold = 1'b1;
        held++;
      end else begin
        hold = 1'b0;
        held = 0;
        r++;
      end
      next();
    end
    hold = 1'b0;
    msg_valid = 1'b0;
    start = 1'b0;
    in_round = 1'b0;
    next();
    start = noise;
    next();
    start = 1'b0;
    settle();
    check("add_time",  add_cyc - t, exp_done - 1);
    check("done_time", done_cyc - t, exp_done);
    check("add_count",  cnt_add - b_add, 1);
    check("done_count", cnt_done - b_done, 1);
    check("we_count",   cnt_we - b_we, 16);
    check("rnd_count",  cnt_rnd - b_rnd, 64);
    check("init_count", cnt_init - b_init, int'(f));
    if (f) check("init_time", init_cyc - t, 0);
    check("idx_seq",   idx_bad - b_idx, 0);
    check("k_seq",     k_bad - b_k, 0);
    check("wsel_seq",  sel_bad - b_sel, 0);
    check("hold_frz",  hold_bad - b_hold, 0);
    check("ready_end", int'(ready), 1);
    check("busy_end",  int'(busy), 0);
  endtask

  initial begin
    int b_add, b_done, t;
    rst_n = 1'b0;
    repeat (3) next();
    rst_n = 1'b1;
    settle();
    check("reset_outs", int'({msg_ready, w_we, w_idx, w_sel, k_addr, rnd_en,
                              init_hv, add_en, ready, busy, done}), 4);
    next();

    // Stray word in IDLE
    msg_valid = 1'b1;
    settle();
    check("idle_we", int'(w_we), 0);
    next();
    msg_valid = 1'b0;
    settle();
    check("idle_stay", int'(ready), 1);
    next();

    do_block(1'b1, 1'b0, 1'b0, 1'b0, 82);
    // Second block accepted at the earliest cycle, with noise inputs
    do_block(1'b0, 1'b0, 1'b0, 1'b1, 82);
    next();
    do_block(1'b1, 1'b1, 1'b0, 1'b0, 98);
    do_block(1'b0, 1'b0, 1'b1, 1'b0, 88);

    // Abort at round 40
    b_add = cnt_add;
    b_done = cnt_done;
    start = 1'b1;
    first = 1'b1;
    t = cyc;
    next();
    start = 1'b0;
    first = 1'b0;
    msg_valid = 1'b1;
    repeat (16) next();
    msg_valid = 1'b0;
    in_round = 1'b1;
    repeat (40) next();
    settle();
    check("abort_k40", int'(k_addr), 40);
    check("abort_cyc", cyc - t, 57);
    abort = 1'b1;
    next();
    abort = 1'b0;
    in_round = 1'b0;
    settle();
    check("abort_ready", int'(ready), 1);
    check("abort_busy",  int'(busy), 0);
    check("abort_k0",    int'(k_addr), 0);
    repeat (60) next();
    check("abort_noadd",  cnt_add - b_add, 0);
    check("abort_nodone", cnt_done - b_done, 0);
    do_block(1'b1, 1'b0, 1'b0, 1'b0, 82);

    // Reset during LOAD after 7 words
    b_add = cnt_add;
    b_done = cnt_done;
    start = 1'b1;
    next();
    start = 1'b0;
    msg_valid = 1'b1;
    repeat (7) next();
    settle();
    check("rst_widx7", int'(w_idx), 7);
    rst_n = 1'b0;
    msg_valid = 1'b0;
    next();
    rst_n = 1'b1;
    settle();
    check("rst_ready", int'(ready), 1);
    check("rst_widx0", int'(w_idx), 0);
    repeat (90) next();
    check("rst_noadd",  cnt_add - b_add, 0);
    check("rst_nodone", cnt_done - b_done, 0);
    do_block(1'b1, 1'b0, 1'b0, 1'b0, 82);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
